pipe_stage_chain: RTL and testbench
===================================

// Module: pipe_stage_chain
// PURPOSE
//  Parametrised chain of pipeline boundary registers (IF/ID/EX/MEM/WB style) used by top.
//  Carries a valid bit plus a DATA_W-bit payload through NUM_STAGES registers with
//  valid/ready handshake, per-stage stall and per-stage flush.
//  Replaces hand-written per-boundary registers; provides one uniform stall/flush contract.
// PARAMETERS
//  NUM_STAGES  4   number of register stages; must be >= 1
//  DATA_W      64  payload width, e.g. {PC, instruction}
//  CNT_W       32  width of the performance counters
// PORTS
//  CLK        in   1             clock, all state on rising edge
//  RESET      in   1             asynchronous, active-low reset
//  IN_VALID   in   1             upstream item present
//  IN_DATA    in   DATA_W        upstream payload
//  IN_READY   out  1             chain accepts item this cycle (combinational)
//  OUT_VALID  out  1             item at last stage offered downstream
//  OUT_DATA   out  DATA_W        payload of last stage
//  OUT_READY  in   1             downstream accepts
//  STALL      in   NUM_STAGES    STALL[i]=1: stage i holds its contents and does not pass them on
//  FLUSH      in   NUM_STAGES    FLUSH[i]=1: stage i invalidated at next edge
//  OCC        out  NUM_STAGES    valid bit of each stage (stage 0 = input side)
//  STALL_CNT  out  CNT_W         performance counter (see CONFIGURATION)
//  FLUSH_CNT  out  CNT_W         performance counter (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (RESET=0, async): all v[i]=0; all data regs=0; counters=0.
//    So OUT_VALID=0, OUT_DATA=0, OCC=0; IN_READY = ~STALL[0] while in reset.
//  - Accept chain, combinational, i = N-1 down to 0:
//    acc[N]=OUT_READY; acc[i] = ~STALL[i] & (~v[i] | acc[i+1]).
//  - IN_READY = acc[0]. OUT_VALID = v[N-1] & ~STALL[N-1]. OUT_DATA = data[N-1].
//  - Upstream offer into stage i: src_v[0] = IN_VALID; src_v[i] = v[i-1] & ~STALL[i-1].
//  - Next state of stage i, in priority order:
//    1. FLUSH[i]: v[i] <= 0; data held. An item moving into stage i this cycle is dropped;
//       the sender still sees it as accepted and vacates.
//    2. acc[i]: v[i] <= src_v[i]. data[i] <= src data only when src_v[i]=1,
//       otherwise data held (bubble).
//    3. Otherwise hold.
//  - FLUSH beats STALL on the same stage. Stall on stage i inserts a bubble into stage i+1
//    when i+1 drains. Stall backpressures stages < i via the acc chain.
//  - Latency N cycles IN fire -> OUT_VALID with no stall; throughput 1 item/cycle; order preserved.
//  - Full chain: IN_READY=0 unless the last stage drains that cycle (bubble-free pass-through).
//  - No combinational path from IN_VALID/IN_DATA to outputs. IN_READY depends combinationally
//    on OUT_READY and STALL (chain of depth N, documented timing path).
// CONFIGURATION
//  Macro PIPE_PERF_CNT_EN.
//  - Defined:
//    STALL_CNT +1 each cycle where |(STALL & OCC).
//    FLUSH_CNT += popcount(FLUSH & OCC), the valid items killed.
//    Both counters saturate at all-ones.
//  - Undefined: no counter registers; STALL_CNT and FLUSH_CNT tied to 0. Ports always present.
// STRUCTURE
//  - Package pipe_pkg: default DATA_W/NUM_STAGES constants, popcount function,
//    stage-index localparams (STG_IFID=0, STG_IDEX=1, STG_EXMEM=2, STG_MEMWB=3).
//  - Sub-module pipe_stage_reg: one valid+data register with flush/load/hold priority.
//    Instantiated NUM_STAGES times in a generate loop. The acc chain lives in the parent.
// TESTING (NUM_STAGES=4, DATA_W=32, PIPE_PERF_CNT_EN defined)
//  1. Reset release, stream 0x1..0x8 with OUT_READY=1 -> 0x1 on OUT 4 cycles after its
//     IN fire, then one per cycle in order.
//  2. OUT_READY=0, continuous input -> OCC=4'b1111, IN_READY=0. OUT_READY=1 ->
//     items drain in order, no loss or duplicate.
//  3. Stream with STALL=4'b0010 for 3 cycles -> stages 0,1 hold, OCC[2] shows bubble,
//     STALL_CNT=3, order intact.
//  4. Chain holds A,B,C,D (D in stage 0), FLUSH=4'b0011 one cycle -> OCC=4'b1100;
//     only A,B emitted; FLUSH_CNT=2.
//  5. STALL[1]=1 and FLUSH[1]=1 same cycle with stage 1 valid -> OCC[1]=0 next cycle
//     (flush wins).
//  6. RESET=0 mid-stream between edges -> OUT_VALID, OCC, counters 0 immediately;
//     after release first input reappears at OUT after 4 cycles.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants, stage indices and popcount helper for pipe_stage_chain
package pipe_pkg;

    localparam int PIPE_NUM_STAGES = 4;
    localparam int PIPE_DATA_W     = 64;
    localparam int PIPE_CNT_W      = 32;

    localparam int STG_IFID  = 0;
    localparam int STG_IDEX  = 1;
    localparam int STG_EXMEM = 2;
    localparam int STG_MEMWB = 3;

    localparam int POPCNT_MAX_W = 32;

    function automatic int unsigned popcount(input logic [POPCNT_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POPCNT_MAX_W; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - one valid+payload boundary register, priority flush > load > hold
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic              src_valid_i,
    input  logic [DATA_W-1:0] src_data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Payload only moves with a real item; a loaded bubble keeps the old data.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = src_valid_i;
            if (src_valid_i) begin
                data_d = src_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - valid/ready pipeline register chain with per-stage stall and flush
// Optional PIPE_PERF_CNT_EN adds saturating stall/flush performance counters.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int NUM_STAGES = PIPE_NUM_STAGES,
    parameter int DATA_W     = PIPE_DATA_W,
    parameter int CNT_W      = PIPE_CNT_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    input  logic [DATA_W-1:0]     in_data_i,
    output logic                  in_ready_o,
    output logic                  out_valid_o,
    output logic [DATA_W-1:0]     out_data_o,
    input  logic                  out_ready_i,
    input  logic [NUM_STAGES-1:0] stall_i,
    input  logic [NUM_STAGES-1:0] flush_i,
    output logic [NUM_STAGES-1:0] occ_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    logic [NUM_STAGES:0]   acc;
    logic [NUM_STAGES-1:0] src_valid;
    logic [NUM_STAGES-1:0] occ;
    logic [DATA_W-1:0]     stage_data [NUM_STAGES];

    // Ready ripples from the output back to the input: a deliberate depth-N timing path.
    always_comb begin
        acc             = '0;
        acc[NUM_STAGES] = out_ready_i;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            acc[i] = ~stall_i[i] & (~occ[i] | acc[i+1]);
        end
    end

    always_comb begin
        src_valid    = '0;
        src_valid[0] = in_valid_i;
        for (int i = 1; i < NUM_STAGES; i++) begin
            src_valid[i] = occ[i-1] & ~stall_i[i-1];
        end
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        logic [DATA_W-1:0] src_data;
        if (g == 0) begin : g_first
            assign src_data = in_data_i;
        end else begin : g_next
            assign src_data = stage_data[g-1];
        end

        pipe_stage_reg #(.DATA_W(DATA_W)) u_reg (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .flush_i     (flush_i[g]),
            .load_i      (acc[g]),
            .src_valid_i (src_valid[g]),
            .src_data_i  (src_data),
            .valid_o     (occ[g]),
            .data_o      (stage_data[g])
        );
    end

    assign in_ready_o  = acc[0];
    assign out_valid_o = occ[NUM_STAGES-1] & ~stall_i[NUM_STAGES-1];
    assign out_data_o  = stage_data[NUM_STAGES-1];
    assign occ_o       = occ;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W:0]   flush_sum;

    // Kill count assumes NUM_STAGES <= POPCNT_MAX_W.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((|(stall_i & occ)) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_sum   = {1'b0, flush_cnt_q}
                    + (CNT_W+1)'(popcount(POPCNT_MAX_W'(flush_i & occ)));
        flush_cnt_d = flush_sum[CNT_W] ? {CNT_W{1'b1}} : flush_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb/tb_pipe_stage_chain.sv - self-checking bench for pipe_stage_chain (queue scoreboard + vector table)
module tb_pipe_stage_chain;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [N-1:0]  stall;
    logic [N-1:0]  flush;
    logic [N-1:0]  occ;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    always #5 clk = ~clk;

    pipe_stage_chain #(.NUM_STAGES(N), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ready_i (out_ready),
        .stall_i     (stall),
        .flush_i     (flush),
        .occ_o       (occ),
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] sbq[$];
    int unsigned   m_stall_cnt = 0;
    int unsigned   m_flush_cnt = 0;
    int unsigned   n_out = 0;

    typedef struct {
        logic [N-1:0] stall;
        logic         out_ready;
        logic         exp_in_ready;
        logic         exp_out_valid;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_cnt(input int unsigned m);
`ifdef PIPE_PERF_CNT_EN
        return 64'(m);
`else
        return 64'(0 * m);
`endif
    endfunction

    task automatic chk_counters(input string tag);
        chk({tag, "_stall_cnt"}, 64'(stall_cnt), exp_cnt(m_stall_cnt));
        chk({tag, "_flush_cnt"}, 64'(flush_cnt), exp_cnt(m_flush_cnt));
    endtask

    // Called right after a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        logic          in_f, out_f, fl;
        logic [DW-1:0] od, id, exp_d;
        logic [N-1:0]  so, fo;
        #3;
        in_f = in_valid & in_ready;
        out_f = out_valid & out_ready;
        od = out_data;
        id = in_data;
        so = stall & occ;
        fo = flush & occ;
        fl = |flush;
        @(posedge clk);
        if (|so) m_stall_cnt++;
        m_flush_cnt += $countones(fo);
        if (out_f) begin
            n_out++;
            if (sbq.size() == 0) begin
                chk("sb_unexpected_output", 64'(od), 64'hDEAD_0000);
            end else begin
                exp_d = sbq.pop_front();
                chk("sb_order", 64'(od), 64'(exp_d));
            end
        end
        if (in_f) sbq.push_back(id);
        @(negedge clk);
        if (!fl) chk("occ_count", 64'($countones(occ)), 64'(sbq.size()));
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        stall     = '0;
        flush     = '0;
    endtask

    task automatic drain(input int cycles);
        idle_inputs();
        out_ready = 1'b1;
        for (int i = 0; i < cycles; i++) cycle();
    endtask

    initial begin
        int          lat;
        logic [CW-1:0] s0, f0;
        int unsigned o0;

        tbl[0] = '{stall: 4'b0000, out_ready: 1'b1, exp_in_ready: 1'b1, exp_out_valid: 1'b1};
        tbl[1] = '{stall: 4'b0000, out_ready: 1'b0, exp_in_ready: 1'b0, exp_out_valid: 1'b1};
        tbl[2] = '{stall: 4'b1000, out_ready: 1'b1, exp_in_ready: 1'b0, exp_out_valid: 1'b0};
        tbl[3] = '{stall: 4'b0001, out_ready: 1'b1, exp_in_ready: 1'b0, exp_out_valid: 1'b1};
        tbl[4] = '{stall: 4'b0100, out_ready: 1'b1, exp_in_ready: 1'b0, exp_out_valid: 1'b1};
        tbl[5] = '{stall: 4'b1111, out_ready: 1'b1, exp_in_ready: 1'b0, exp_out_valid: 1'b0};
        tbl[6] = '{stall: 4'b0010, out_ready: 1'b0, exp_in_ready: 1'b0, exp_out_valid: 1'b1};

        // Reset state
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_occ", 64'(occ), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_in_ready_nostall", 64'(in_ready), 64'(1));
        stall = 4'b0001;
        #1;
        chk("rst_in_ready_stall0", 64'(in_ready), 64'(0));
        stall = '0;
        chk_counters("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: latency and in-order streaming
        out_ready = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            in_valid = (k <= 8);
            in_data  = (k <= 8) ? DW'(k) : '0;
            cycle();
            if (k <= 3) chk("t1_not_yet_valid", 64'(out_valid), 64'(0));
            if (k == 4) begin
                chk("t1_first_valid", 64'(out_valid), 64'(1));
                chk("t1_first_data", 64'(out_data), 64'(1));
            end
        end
        chk("t1_all_out", 64'(n_out), 64'(8));
        chk("t1_empty", 64'(occ), 64'(0));

        // 2: fill against backpressure, then combinational ready vectors on a full chain
        idle_inputs();
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_data = 32'h100 + DW'(k);
            cycle();
        end
        chk("t2_full_occ", 64'(occ), 64'hF);
        chk("t2_full_in_ready", 64'(in_ready), 64'(0));
        in_valid = 1'b0;
        foreach (tbl[v]) begin
            #1;
            stall     = tbl[v].stall;
            out_ready = tbl[v].out_ready;
            #1;
            chk($sformatf("t2_vec%0d_in_ready", v), 64'(in_ready), 64'(tbl[v].exp_in_ready));
            chk($sformatf("t2_vec%0d_out_valid", v), 64'(out_valid), 64'(tbl[v].exp_out_valid));
            stall     = '0;
            out_ready = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        chk("t2_still_full", 64'(occ), 64'hF);
        drain(6);
        chk("t2_drained", 64'(occ), 64'(0));
        chk_counters("t2");

        // 3: stall stage 1 mid-stream
        idle_inputs();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 32'h200 + DW'(k);
            cycle();
        end
        s0 = stall_cnt;
        stall = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            in_data = 32'h210 + DW'(k);
            cycle();
            if (k == 0) chk("t3_bubble_occ2", 64'(occ[2]), 64'(0));
            chk("t3_hold_occ1", 64'(occ[1]), 64'(1));
        end
        chk("t3_stall_cnt_delta", 64'(stall_cnt - s0), exp_cnt(3));
        stall = '0;
        in_data = 32'h220;
        cycle();
        drain(8);
        chk("t3_drained", 64'(occ), 64'(0));
        chk_counters("t3");

        // 4: flush the two youngest items of a full chain
        idle_inputs();
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 32'hA + DW'(k);
            cycle();
        end
        chk("t4_full", 64'(occ), 64'hF);
        in_valid = 1'b0;
        f0 = flush_cnt;
        flush = 4'b0011;
        cycle();
        flush = '0;
        chk("t4_occ_after_flush", 64'(occ), 64'hC);
        chk("t4_flush_cnt_delta", 64'(flush_cnt - f0), exp_cnt(2));
        sbq = '{32'hA, 32'hB};
        o0 = n_out;
        drain(5);
        chk("t4_only_two_out", 64'(n_out - o0), 64'(2));
        chk_counters("t4");

        // 5: flush and stall together on a valid stage 1
        idle_inputs();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h55;
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("t5_in_stage1", 64'(occ), 64'h2);
        stall = 4'b0010;
        flush = 4'b0010;
        cycle();
        stall = '0;
        flush = '0;
        chk("t5_flush_wins", 64'(occ[1]), 64'(0));
        sbq.delete();
        chk_counters("t5");

        // 6: asynchronous reset between edges
        idle_inputs();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 32'h300 + DW'(k);
            cycle();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_occ", 64'(occ), 64'(0));
        chk("t6_async_out_valid", 64'(out_valid), 64'(0));
        chk("t6_async_stall_cnt", 64'(stall_cnt), 64'(0));
        chk("t6_async_flush_cnt", 64'(flush_cnt), 64'(0));
        idle_inputs();
        sbq.delete();
        m_stall_cnt = 0;
        m_flush_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'h77;
        cycle();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            cycle();
            lat++;
        end
        chk("t6_latency", 64'(lat), 64'(4));
        chk("t6_data", 64'(out_data), 64'h77);
        drain(3);

        // Random traffic with stalls against the queue scoreboard
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            stall     = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            flush     = '0;
            cycle();
        end
        drain(10);
        chk("rand_queue_empty", 64'(sbq.size()), 64'(0));
        chk("rand_occ_empty", 64'(occ), 64'(0));
        chk_counters("rand");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
